// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared state encoding, default widths and width helpers for the fetch front end
package fetch_pkg;

  // FSM state encoding
  localparam int STATE_W = 3;
  localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
  localparam logic [STATE_W-1:0] ST_ISSUE = 3'd1;
  localparam logic [STATE_W-1:0] ST_WAIT  = 3'd2;
  localparam logic [STATE_W-1:0] ST_CAPT  = 3'd3;
  localparam logic [STATE_W-1:0] ST_HOLD  = 3'd4;

  // Default geometry of the fetch path
  localparam int DEF_ADDR_W  = 3;
  localparam int DEF_OPND_W  = 10;
  localparam int DEF_DATA_W  = 8;
  localparam int DEF_DEPTH   = 8;
  localparam int DEF_MEM_LAT = 1;

  // Packed instruction is {addr, operand}
  function automatic int instr_width(input int addr_w, input int opnd_w);
    return addr_w + opnd_w;
  endfunction

  // Result word is {data, operand}
  function automatic int out_width(input int data_w, input int opnd_w);
    return data_w + opnd_w;
  endfunction

  // Occupancy counter must be able to hold the value DEPTH itself
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Bit position of the lowest address bit inside a packed instruction
  function automatic int addr_lsb(input int opnd_w);
    return opnd_w;
  endfunction

  // Latency down-counter only needs to reach MEM_LAT-1; keep at least 1 bit
  function automatic int lat_width(input int mem_lat);
    return (mem_lat < 2) ? 1 : $clog2(mem_lat);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - instruction FIFO with occupancy count and synchronous flush
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int WIDTH = 13,
  parameter int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push_valid,
  input  logic [WIDTH-1:0] push_data,
  output logic             push_ready,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             full;
  logic             push_ok;
  logic             pop_ok;

  // Flush wins over both ports so a word offered during flush is dropped
  always_comb begin
    full       = (count_q == CNT_W'(DEPTH));
    empty      = (count_q == '0);
    push_ready = !full;
    push_ok    = push_valid && !full && !flush;
    pop_ok     = pop && !empty && !flush;
    head_data  = mem_q[rd_ptr_q];
    count      = count_q;
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      unique case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage array needs no reset; only slots below count are ever read out
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/fetch_unit_pipe.sv
// rtl/fetch_unit_pipe.sv - instruction fetch front end: FIFO, memory read sequencing, result handshake
module fetch_unit_pipe
  import fetch_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int OPND_W  = DEF_OPND_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int MEM_LAT = DEF_MEM_LAT,
  localparam int INSTR_W = instr_width(ADDR_W, OPND_W),
  localparam int OUT_W   = out_width(DATA_W, OPND_W),
  localparam int CNT_W   = cnt_width(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               flush,
  input  logic               in_valid,
  input  logic [INSTR_W-1:0] in_data,
  output logic               in_ready,
  output logic               mem_ren,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [DATA_W-1:0]  mem_rdata,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OUT_W-1:0]   out_data,
  output logic [CNT_W-1:0]   fifo_count,
  output logic               busy,
  output logic               done
);

  localparam int A_LSB = addr_lsb(OPND_W);
  localparam int LAT_W = lat_width(MEM_LAT);

  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] state_d;
  logic [INSTR_W-1:0] head_data;
  logic [ADDR_W-1:0]  head_addr;
  logic [OPND_W-1:0]  head_opnd;
  logic [ADDR_W-1:0]  addr_q;
  logic [OPND_W-1:0]  opnd_q;
  logic [LAT_W-1:0]   lat_cnt_q;
  logic               out_valid_q;
  logic [OUT_W-1:0]   out_data_q;
  logic               done_q;
  logic               fifo_empty;
  logic               fifo_pop;
  logic               push_ok;
  logic               handshake;
  logic               more_work;

  fetch_fifo #(
    .WIDTH (INSTR_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .push_valid (in_valid),
    .push_data  (in_data),
    .push_ready (in_ready),
    .pop        (fifo_pop),
    .head_data  (head_data),
    .empty      (fifo_empty),
    .count      (fifo_count)
  );

  // Field split of the FIFO head and handshake qualifiers
  always_comb begin
    head_addr = head_data[A_LSB +: ADDR_W];
    head_opnd = head_data[OPND_W-1:0];
    push_ok   = in_valid && in_ready;
    handshake = out_valid_q && out_ready;
    // A word accepted in the same cycle as the result leaves is enough to keep going
    more_work = !fifo_empty || push_ok;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; flush returns to IDLE from anywhere
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (start && !fifo_empty) state_d = ST_ISSUE;
        ST_ISSUE: state_d = (MEM_LAT > 1) ? ST_WAIT : ST_CAPT;
        ST_WAIT:  if (lat_cnt_q == LAT_W'(1)) state_d = ST_CAPT;
        ST_CAPT:  state_d = ST_HOLD;
        ST_HOLD:  if (handshake) state_d = more_work ? ST_ISSUE : ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // State-decoded outputs; address reads the head live in ISSUE and holds afterwards
  always_comb begin
    mem_ren   = (state_q == ST_ISSUE);
    mem_addr  = mem_ren ? head_addr : addr_q;
    fifo_pop  = mem_ren;
    busy      = (state_q != ST_IDLE);
    out_valid = out_valid_q;
    out_data  = out_data_q;
    done      = done_q;
  end

  // Datapath: operand latch, latency counter, result register and done pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q      <= '0;
      opnd_q      <= '0;
      lat_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      done_q      <= 1'b0;
    end else if (flush) begin
      lat_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start && fifo_empty) done_q <= 1'b1;
        end
        ST_ISSUE: begin
          addr_q    <= head_addr;
          opnd_q    <= head_opnd;
          lat_cnt_q <= LAT_W'(MEM_LAT - 1);
        end
        ST_WAIT: begin
          lat_cnt_q <= lat_cnt_q - LAT_W'(1);
        end
        ST_CAPT: begin
          out_data_q  <= {mem_rdata, opnd_q};
          out_valid_q <= 1'b1;
        end
        ST_HOLD: begin
          if (handshake) begin
            out_valid_q <= 1'b0;
            if (!more_work) done_q <= 1'b1;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
